// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR/SLT, iterative shift-add MUL,
// start/busy/done handshake with registered result and flags.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [5:0] OP_ADD = 6'd27;
  localparam logic [5:0] OP_SUB = 6'd28;
  localparam logic [5:0] OP_AND = 6'd29;
  localparam logic [5:0] OP_OR  = 6'd30;
  localparam logic [5:0] OP_SLT = 6'd31;
  localparam logic [5:0] OP_MUL = 6'd32;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t           state;
  logic [5:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_SLT:  alu_res[0] = $signed(a_q) < $signed(b_q);
      default: alu_ill = 1'b1;
    endcase
  end

  // a_q/b_q double as multiplicand/multiplier shift registers during MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= operation;
            a_q   <= src_a;
            b_q   <= src_b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (operation == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          result  <= alu_res;
          zero    <= (alu_res == '0);
          illegal <= alu_ill;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        MUL: begin
          if (b_q[0]) acc <= acc + a_q;
          a_q <= a_q << 1;
          b_q <= b_q >> 1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          result  <= acc;
          zero    <= (acc == '0);
          illegal <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, multi-cycle
// corner sequences, and randomized ops against a behavioural model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

  alu_exec_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the op code definitions.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill);
    longint unsigned p;
    ill = 1'b0;
    r   = 32'h0;
    p   = longint'(a) * longint'(b);
    case (op)
      6'd27: r = a + b;
      6'd28: r = a - b;
      6'd29: r = a & b;
      6'd30: r = a | b;
      6'd31: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd32: r = p[31:0];
      default: ill = 1'b1;
    endcase
  endfunction

  // done must never be high in two consecutive cycles
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n && done) begin
      vectors++;
      if (prev_done) begin
        miscompares++;
        $display("FAIL done_adjacent: got 1 expected 0");
      end
    end
    prev_done = rst_n & done;
  end

  task automatic do_op(input string nm, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_ill, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    operation = op; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({nm, "_busy"}, {63'b0, busy}, 64'd1);
    src_a = $urandom; src_b = $urandom; operation = 6'($urandom);
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) seen = 1;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_res"}, {32'b0, result}, {32'b0, exp_res});
    chk({nm, "_zero"}, {63'b0, zero}, {63'b0, exp_res == 32'h0});
    chk({nm, "_ill"}, {63'b0, illegal}, {63'b0, exp_ill});
    chk({nm, "_busy_at_done"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    tbl[0] = '{6'd27, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1};
    tbl[1] = '{6'd28, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1};
    tbl[2] = '{6'd31, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1};
    tbl[3] = '{6'd31, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b0, 1};
    tbl[4] = '{6'd29, 32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0, 1};
    tbl[5] = '{6'd30, 32'hF0F0,     32'h0FF0,     32'hFFF0,     1'b0, 1};
    tbl[6] = '{6'd32, 32'h10001,    32'h10001,    32'h00020001, 1'b0, 33};
    tbl[7] = '{6'd40, 32'h1234,     32'h5678,     32'h0,        1'b1, 1};
    tbl[8] = '{6'd27, 32'd2,        32'd3,        32'd5,        1'b0, 1};
    tbl[9] = '{6'd32, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 33};

    rst_n = 1'b0; start = 1'b0; operation = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_result", {32'b0, result}, 64'd0);
    chk("rst_zero", {63'b0, zero}, 64'd1);
    chk("rst_illegal", {63'b0, illegal}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i])
      do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ill, tbl[i].lat);

    // MUL with start pulses and operand churn while busy; ignored and not queued
    begin
      int lat, busy_cnt;
      bit seen;
      @(negedge clk);
      operation = 6'd32; src_a = 32'h10001; src_b = 32'h10001; start = 1'b1;
      @(posedge clk);
      #1 busy_cnt = busy ? 1 : 0;
      lat = 0; seen = 0;
      while (!seen && lat < 100) begin
        @(negedge clk);
        start = (lat < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        operation = 6'd27; src_a = $urandom; src_b = $urandom;
        @(posedge clk);
        lat++;
        #1;
        if (done) seen = 1;
        else if (busy) busy_cnt++;
      end
      start = 1'b0;
      chk("mulign_lat", 64'(lat), 64'd33);
      chk("mulign_busy_cycles", 64'(busy_cnt), 64'd33);
      chk("mulign_res", {32'b0, result}, 64'h00020001);
      seen = 0;
      repeat (5) begin
        @(posedge clk);
        #1 if (done || busy) seen = 1;
      end
      chk("mulign_not_queued", {63'b0, seen}, 64'd0);
    end

    // reset in the middle of a MUL: abort, reset values, no done
    begin
      bit seen;
      do_op("pre_rst_add", 6'd27, 32'd2, 32'd3, 32'd5, 1'b0, 1);
      @(negedge clk);
      operation = 6'd32; src_a = 32'h1234; src_b = 32'h5678; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("midrst_busy", {63'b0, busy}, 64'd0);
      chk("midrst_result", {32'b0, result}, 64'd0);
      chk("midrst_zero", {63'b0, zero}, 64'd1);
      chk("midrst_done", {63'b0, done}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1 if (done || busy) seen = 1;
      end
      chk("midrst_no_done", {63'b0, seen}, 64'd0);
      do_op("post_rst_mul", 6'd32, 32'd3, 32'd4, 32'd12, 1'b0, 33);
    end

    // back-to-back: start held through the done cycle
    @(negedge clk);
    operation = 6'd27; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 operation = 6'd28; src_a = 32'd10; src_b = 32'd4;
    @(posedge clk);
    #1;
    chk("b2b_done1", {63'b0, done}, 64'd1);
    chk("b2b_res1", {32'b0, result}, 64'd5);
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_gap_done", {63'b0, done}, 64'd0);
    chk("b2b_gap_busy", {63'b0, busy}, 64'd1);
    @(posedge clk);
    #1;
    chk("b2b_done2", {63'b0, done}, 64'd1);
    chk("b2b_res2", {32'b0, result}, 64'd6);
    @(posedge clk);
    #1;
    chk("b2b_after_done", {63'b0, done}, 64'd0);
    chk("b2b_after_busy", {63'b0, busy}, 64'd0);

    // randomized ops against the model
    for (int n = 0; n < 150; n++) begin
      logic [5:0]  op;
      logic [31:0] a, b, r;
      logic        ill;
      int unsigned k;
      k = $urandom_range(0, 9);
      if (k <= 5) op = 6'(27 + k);
      else begin
        op = 6'($urandom_range(0, 63));
        if (op >= 6'd27 && op <= 6'd32) op = op + 6'd8;
      end
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = (k[0]) ? 32'h80000000 : 32'h7FFFFFFF;
      if ($urandom_range(0, 3) == 0) b = (k[1]) ? 32'h0 : 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) b = a;
      model(op, a, b, r, ill);
      do_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, r, ill, (op == 6'd32) ? 33 : 1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
